// File: rtl/instr_decode_pkg.sv
// Shared MIPS decode constants: cmd codes consumed by the control FSM, opcode and funct values.
package instr_decode_pkg;

    typedef enum logic [3:0] {
        CMD_LW      = 4'd0,
        CMD_SW      = 4'd1,
        CMD_J       = 4'd2,
        CMD_JR      = 4'd3,
        CMD_JAL     = 4'd4,
        CMD_BEQ     = 4'd5,
        CMD_BNE     = 4'd6,
        CMD_XORI    = 4'd7,
        CMD_ADDI    = 4'd8,
        CMD_ADD     = 4'd9,
        CMD_SUB     = 4'd10,
        CMD_SLT     = 4'd11,
        CMD_ILLEGAL = 4'd15
    } cmd_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/instr_decode_if.sv
// Memory-side and decode-side signals of the instruction decode stage.
// Counter signals exist only when DECODE_STATS_EN is defined.
interface instr_decode_if #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int ILL_CNT_W = 16
);
    logic              irWe;
    logic [DATA_W-1:0] memOut;
    logic [3:0]        cmd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] sxi;
    logic [DATA_W-1:0] sxis;
    logic [25:0]       jAddr;
    logic [DATA_W-1:0] mdr;
    logic              irValid;
    logic              illegal;
    logic              illegalSeen;

    if (DATA_W < 32 || CNT_W < 1 || ILL_CNT_W < 1) begin : g_param_chk
        $error("instr_decode_if: DATA_W must be >= 32 and counter widths >= 1");
    end

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0]     instrCount;
    logic [ILL_CNT_W-1:0] illegalCount;

    modport master (
        output irWe, memOut,
        input  cmd, rs, rt, rd, sxi, sxis, jAddr, mdr, irValid, illegal, illegalSeen,
        input  instrCount, illegalCount
    );
    modport slave (
        input  irWe, memOut,
        output cmd, rs, rt, rd, sxi, sxis, jAddr, mdr, irValid, illegal, illegalSeen,
        output instrCount, illegalCount
    );
`else
    modport master (
        output irWe, memOut,
        input  cmd, rs, rt, rd, sxi, sxis, jAddr, mdr, irValid, illegal, illegalSeen
    );
    modport slave (
        input  irWe, memOut,
        output cmd, rs, rt, rd, sxi, sxis, jAddr, mdr, irValid, illegal, illegalSeen
    );
`endif

endinterface

// File: rtl/instr_decode_cmd_lut.sv
// Purely combinational opcode/funct -> cmd lookup; unknown encodings map to CMD_ILLEGAL.
module cmd_lut
    import instr_decode_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cmd_e       cmd
);

    always_comb begin
        cmd = CMD_ILLEGAL;
        case (opcode)
            OP_LW:   cmd = CMD_LW;
            OP_SW:   cmd = CMD_SW;
            OP_J:    cmd = CMD_J;
            OP_JAL:  cmd = CMD_JAL;
            OP_BEQ:  cmd = CMD_BEQ;
            OP_BNE:  cmd = CMD_BNE;
            OP_XORI: cmd = CMD_XORI;
            OP_ADDI: cmd = CMD_ADDI;
            OP_RTYPE: begin
                case (funct)
                    FN_JR:   cmd = CMD_JR;
                    FN_ADD:  cmd = CMD_ADD;
                    FN_SUB:  cmd = CMD_SUB;
                    FN_SLT:  cmd = CMD_SLT;
                    default: cmd = CMD_ILLEGAL;
                endcase
            end
            default: cmd = CMD_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// Instruction register + decode stage of the multicycle MIPS CPU.
// Optional retired/illegal counters under DECODE_STATS_EN.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    instr_decode_if.slave  bus
);

    if (DATA_W < 32 || CNT_W < 1 || ILL_CNT_W < 1) begin : g_param_chk
        $error("instr_decode: DATA_W must be >= 32 and counter widths >= 1");
    end

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              ir_valid_q, ir_valid_d;
    logic              ill_seen_q, ill_seen_d;
    logic              ill_load;
    cmd_e              ir_cmd, mem_cmd, cmd;
    logic [DATA_W-1:0] sext16;

    cmd_lut u_ir_lut (
        .opcode (ir_q[31:26]),
        .funct  (ir_q[5:0]),
        .cmd    (ir_cmd)
    );

    // Second lookup on the incoming word lets illegalSeen set on the load edge itself.
    cmd_lut u_mem_lut (
        .opcode (bus.memOut[31:26]),
        .funct  (bus.memOut[5:0]),
        .cmd    (mem_cmd)
    );

    always_comb begin
        ill_load   = bus.irWe && (mem_cmd == CMD_ILLEGAL);
        ir_d       = bus.irWe ? bus.memOut : ir_q;
        ir_valid_d = ir_valid_q | bus.irWe;
        ill_seen_d = ill_seen_q | ill_load;
        mdr_d      = bus.memOut;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= '0;
            mdr_q      <= '0;
            ir_valid_q <= 1'b0;
            ill_seen_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            ir_valid_q <= ir_valid_d;
            ill_seen_q <= ill_seen_d;
        end
    end

    always_comb begin
        cmd    = ir_valid_q ? ir_cmd : CMD_ILLEGAL;
        sext16 = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    end

    assign bus.cmd         = cmd;
    assign bus.rs          = ir_q[25:21];
    assign bus.rt          = ir_q[20:16];
    assign bus.rd          = (cmd == CMD_JAL) ? REG_RA : ir_q[15:11];
    assign bus.sxi         = (cmd == CMD_XORI) ? {{(DATA_W-16){1'b0}}, ir_q[15:0]} : sext16;
    assign bus.sxis        = {sext16[DATA_W-3:0], 2'b00};
    assign bus.jAddr       = ir_q[25:0];
    assign bus.mdr         = mdr_q;
    assign bus.irValid     = ir_valid_q;
    assign bus.illegal     = ir_valid_q && (cmd == CMD_ILLEGAL);
    assign bus.illegalSeen = ill_seen_q;

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0]     instr_cnt_q, instr_cnt_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        if (bus.irWe && (instr_cnt_q != '1))
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        if (ill_load && (ill_cnt_q != '1))
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            ill_cnt_q   <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign bus.instrCount   = instr_cnt_q;
    assign bus.illegalCount = ill_cnt_q;
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Table-driven bench for instr_decode with a scoreboard queue; small counter widths expose saturation.
module tb_instr_decode;

    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int LW    = 2;
    localparam int IC_MAX = (1 << CW) - 1;
    localparam int LC_MAX = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_decode_if #(.DATA_W(DW), .CNT_W(CW), .ILL_CNT_W(LW)) bus ();

    instr_decode #(.DATA_W(DW), .CNT_W(CW), .ILL_CNT_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] mem;
        logic [3:0]  cmd;
        logic [4:0]  rs, rt, rd;
        logic [31:0] sxi, sxis;
        logic [25:0] ja;
        logic        ill;
        logic        seen;
    } vec_t;

    typedef struct {
        vec_t v;
        int   ic;
        int   lc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_ic = 0;
    int   exp_lc = 0;

    function automatic vec_t mk(logic we, logic [31:0] mem, logic [3:0] cmd,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] sxi, logic [31:0] sxis, logic [25:0] ja,
                                logic ill, logic seen);
        vec_t v;
        v.we = we; v.mem = mem; v.cmd = cmd; v.rs = rs; v.rt = rt; v.rd = rd;
        v.sxi = sxi; v.sxis = sxis; v.ja = ja; v.ill = ill; v.seen = seen;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, " cmd"},         32'(bus.cmd), 32'd15);
        chk({tag, " irValid"},     32'(bus.irValid), 32'd0);
        chk({tag, " illegal"},     32'(bus.illegal), 32'd0);
        chk({tag, " illegalSeen"}, 32'(bus.illegalSeen), 32'd0);
        chk({tag, " mdr"},         bus.mdr, 32'd0);
        chk({tag, " jAddr"},       32'(bus.jAddr), 32'd0);
        chk({tag, " rd"},          32'(bus.rd), 32'd0);
`ifdef DECODE_STATS_EN
        chk({tag, " instrCount"},   32'(bus.instrCount), 32'd0);
        chk({tag, " illegalCount"}, 32'(bus.illegalCount), 32'd0);
`endif
    endtask

    // Drive one cycle, push expectation, compare once the edge has happened.
    task automatic step(vec_t v);
        exp_t e;
        @(negedge clk);
        bus.irWe   = v.we;
        bus.memOut = v.mem;
        if (v.we && exp_ic < IC_MAX) exp_ic++;
        if (v.we && v.cmd == 4'd15 && exp_lc < LC_MAX) exp_lc++;
        e.v = v; e.ic = exp_ic; e.lc = exp_lc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("cmd",         32'(bus.cmd),         32'(e.v.cmd));
        chk("rs",          32'(bus.rs),          32'(e.v.rs));
        chk("rt",          32'(bus.rt),          32'(e.v.rt));
        chk("rd",          32'(bus.rd),          32'(e.v.rd));
        chk("sxi",         bus.sxi,              e.v.sxi);
        chk("sxis",        bus.sxis,             e.v.sxis);
        chk("jAddr",       32'(bus.jAddr),       32'(e.v.ja));
        chk("mdr",         bus.mdr,              e.v.mem);
        chk("irValid",     32'(bus.irValid),     32'd1);
        chk("illegal",     32'(bus.illegal),     32'(e.v.ill));
        chk("illegalSeen", 32'(bus.illegalSeen), 32'(e.v.seen));
`ifdef DECODE_STATS_EN
        chk("instrCount",   32'(bus.instrCount),   32'(e.ic));
        chk("illegalCount", 32'(bus.illegalCount), 32'(e.lc));
`endif
        bus.irWe = 1'b0;
    endtask

    initial begin
        vec_t last;
        vec_t h;
        bus.irWe   = 1'b0;
        bus.memOut = 32'h0;

        tbl.push_back(mk(1, 32'h8D090004, 4'd0,  8, 9, 0,  32'h4,        32'h10,       26'h1090004, 0, 0));
        tbl.push_back(mk(1, 32'hAD090004, 4'd1,  8, 9, 0,  32'h4,        32'h10,       26'h1090004, 0, 0));
        tbl.push_back(mk(1, 32'h08000010, 4'd2,  0, 0, 0,  32'h10,       32'h40,       26'h0000010, 0, 0));
        tbl.push_back(mk(1, 32'h0C000010, 4'd4,  0, 0, 31, 32'h10,       32'h40,       26'h0000010, 0, 0));
        tbl.push_back(mk(1, 32'h01000008, 4'd3,  8, 0, 0,  32'h8,        32'h20,       26'h1000008, 0, 0));
        tbl.push_back(mk(1, 32'h1109FFFE, 4'd5,  8, 9, 31, 32'hFFFFFFFE, 32'hFFFFFFF8, 26'h109FFFE, 0, 0));
        tbl.push_back(mk(1, 32'h15090003, 4'd6,  8, 9, 0,  32'h3,        32'hC,        26'h1090003, 0, 0));
        tbl.push_back(mk(1, 32'h3928FFFF, 4'd7,  9, 8, 31, 32'h0000FFFF, 32'hFFFFFFFC, 26'h128FFFF, 0, 0));
        tbl.push_back(mk(1, 32'h2128FFFF, 4'd8,  9, 8, 31, 32'hFFFFFFFF, 32'hFFFFFFFC, 26'h128FFFF, 0, 0));
        tbl.push_back(mk(1, 32'h01095022, 4'd10, 8, 9, 10, 32'h5022,     32'h14088,    26'h1095022, 0, 0));
        tbl.push_back(mk(1, 32'h0109502A, 4'd11, 8, 9, 10, 32'h502A,     32'h140A8,    26'h109502A, 0, 0));
        tbl.push_back(mk(1, 32'hFC000000, 4'd15, 0, 0, 0,  32'h0,        32'h0,        26'h0000000, 1, 1));
        tbl.push_back(mk(1, 32'h01095020, 4'd9,  8, 9, 10, 32'h5020,     32'h14080,    26'h1095020, 0, 1));
        tbl.push_back(mk(0, 32'hDEADBEEF, 4'd9,  8, 9, 10, 32'h5020,     32'h14080,    26'h1095020, 0, 1));
        tbl.push_back(mk(1, 32'h01095021, 4'd15, 8, 9, 10, 32'h5021,     32'h14084,    26'h1095021, 1, 1));

        // Reset with no irWe
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("post-reset idle");

        foreach (tbl[i]) begin
            step(tbl[i]);
            last = tbl[i];
        end

        // Hold: IR frozen, mdr follows memOut with one cycle of delay
        for (int k = 0; k < 5; k++) begin
            h     = last;
            h.we  = 1'b0;
            h.mem = $urandom;
            step(h);
        end

        // Reset asserted mid-cycle alongside irWe
        @(negedge clk);
        bus.irWe   = 1'b1;
        bus.memOut = 32'h8D090004;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("mid-cycle reset");
        @(posedge clk);
        #1;
        chk_reset_state("reset over irWe");
        @(negedge clk);
        bus.irWe   = 1'b0;
        bus.memOut = 32'h0;
        rst        = 1'b0;
        exp_ic     = 0;
        exp_lc     = 0;

        // illegalSeen must have been cleared by reset
        step(tbl[0]);

        // Illegal stream drives both counters into saturation
        for (int k = 0; k < 18; k++)
            step(tbl[11]);
        step(tbl[12]);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, 0 required", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
